// File: rtl/time_entry_loader.sv
// rtl/time_entry_loader.sv - keypad entry buffer and digit loader for the countdown timer
module time_entry_loader #(
    parameter bit CLEAR_ON_DONE = 1'b1
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       start,
    input  logic       cancel,
    output logic [3:0] data,
    output logic       load_so,
    output logic       load_st,
    output logic       load_min,
    output logic       load_done,
    output logic       entry_err,
    output logic       busy,
    output logic [3:0] disp_min,
    output logic [3:0] disp_st,
    output logic [3:0] disp_so,
    output logic [1:0] digit_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        L_SO  = 3'd1,
        L_ST  = 3'd2,
        L_MIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_q, state_n;
    logic [3:0] min_n, st_n, so_n, data_n;
    logic [1:0] cnt_n;
    logic       load_so_n, load_st_n, load_min_n, load_done_n, entry_err_n, busy_n;

    // State register; reset drops any load in progress
    always_ff @(posedge clk) begin
        if (!clearn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state, next buffer contents, and the output values for the next cycle
    always_comb begin
        state_n     = state_q;
        min_n       = disp_min;
        st_n        = disp_st;
        so_n        = disp_so;
        cnt_n       = digit_cnt;
        entry_err_n = 1'b0;

        case (state_q)
            IDLE: begin
                if (cancel) begin
                    min_n = 4'd0;
                    st_n  = 4'd0;
                    so_n  = 4'd0;
                    cnt_n = 2'd0;
                end else if (start) begin
                    // An empty entry or seconds-tens above 5 is not a valid time
                    if (digit_cnt == 2'd0 || disp_st > 4'd5) begin
                        entry_err_n = 1'b1;
                    end else begin
                        state_n = L_SO;
                    end
                end else if (key_valid && key <= 4'd9) begin
                    min_n = disp_st;
                    st_n  = disp_so;
                    so_n  = key;
                    if (digit_cnt != 2'd3) begin
                        cnt_n = digit_cnt + 2'd1;
                    end
                end
            end
            L_SO, L_ST, L_MIN: begin
                if (cancel) begin
                    state_n = IDLE;
                    min_n   = 4'd0;
                    st_n    = 4'd0;
                    so_n    = 4'd0;
                    cnt_n   = 2'd0;
                end else if (state_q == L_SO) begin
                    state_n = L_ST;
                end else if (state_q == L_ST) begin
                    state_n = L_MIN;
                end else begin
                    state_n = DONE;
                    // Clearing on entry to DONE makes the buffer read 0 alongside load_done
                    if (CLEAR_ON_DONE) begin
                        min_n = 4'd0;
                        st_n  = 4'd0;
                        so_n  = 4'd0;
                        cnt_n = 2'd0;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are registered alongside it
        load_so_n   = (state_n == L_SO);
        load_st_n   = (state_n == L_ST);
        load_min_n  = (state_n == L_MIN);
        load_done_n = (state_n == DONE);
        busy_n      = load_so_n || load_st_n || load_min_n;

        data_n = 4'd0;
        if (load_so_n) begin
            data_n = disp_so;
        end else if (load_st_n) begin
            data_n = disp_st;
        end else if (load_min_n) begin
            data_n = disp_min;
        end
    end

    // Output and buffer registers
    always_ff @(posedge clk) begin
        if (!clearn) begin
            data      <= 4'd0;
            load_so   <= 1'b0;
            load_st   <= 1'b0;
            load_min  <= 1'b0;
            load_done <= 1'b0;
            entry_err <= 1'b0;
            busy      <= 1'b0;
            disp_min  <= 4'd0;
            disp_st   <= 4'd0;
            disp_so   <= 4'd0;
            digit_cnt <= 2'd0;
        end else begin
            data      <= data_n;
            load_so   <= load_so_n;
            load_st   <= load_st_n;
            load_min  <= load_min_n;
            load_done <= load_done_n;
            entry_err <= entry_err_n;
            busy      <= busy_n;
            disp_min  <= min_n;
            disp_st   <= st_n;
            disp_so   <= so_n;
            digit_cnt <= cnt_n;
        end
    end

endmodule
